data_memory: RTL and testbench
==============================

Name: data_memory

Overview:
- Byte-addressable 32-bit data memory for the mini RISC-V CPU; serves the load/store unit during the MEM stage.
- Implements RV32I load/store widths selected by funct3: LB, LH, LW, LBU, LHU, SB, SH, SW.
- Loads are combinational (same-cycle data); stores commit on the rising clock edge.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words stored; must be a power of two.
- AW, 32, width of the byte address input.

Ports:
- clk  input  1  system clock; all stores commit on its rising edge.
- rstn  input  1  asynchronous active-low reset; clears the whole array.
- addr  input  AW  byte address.
- wdata  input  32  store data; the lower byte/half/word is used according to width.
- we  input  1  write enable; 1 = store this cycle.
- funct3  input  3  access width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- rdata  output  32  load result, already sign- or zero-extended.

Behaviour:
- Storage is DEPTH_WORDS x 32 bits, little-endian. Word index = addr[log2(DEPTH_WORDS)+1:2]; byte offset = addr[1:0].
- Upper address bits beyond the index wrap silently (aliasing); no out-of-range error.
- Reset: while rstn = 0, every word reads 0 and rdata = 0. Reset asserts immediately and asynchronously, including mid-store; any store in that cycle is lost. Stores resume on the first rising edge after rstn deasserts.
- Read path is purely combinational from addr, funct3 and array contents. It is valid regardless of we and reflects array contents before the current cycle's store (no write-through).
- Load formatting by byte offset:
  - B (000): selected byte, sign-extended.
  - BU (100): selected byte, zero-extended.
  - H (001): halfword at offset 0 or 2, sign-extended.
  - HU (101): halfword at offset 0 or 2, zero-extended.
  - W (010): full word.
  - Unused funct3 values (011, 110, 111): rdata = 0.
- Store on rising clk edge when we = 1, using per-byte enables:
  - SB: wdata[7:0] to byte addr[1:0].
  - SH: wdata[15:0] to bytes {addr[1],0} and {addr[1],1}.
  - SW: all four bytes.
  - Unchanged bytes in the word keep their value.
  - Unused funct3 with we = 1: no write.
- Misaligned accesses (halfword with addr[0] = 1, word with addr[1:0] != 0), without the optional feature: offending low bits are forced to 0 and the access proceeds aligned.
- Back-to-back stores to the same word in consecutive cycles merge byte-wise; a load in the following cycle sees both.

Optional Feature:
- Macro: DATA_MEMORY_MISALIGN_TRAP_EN.
- Defined:
  - Adds output port misaligned (1 bit, combinational), high when a halfword/word access is misaligned, regardless of we.
  - On a misaligned store, no bytes are written.
  - On a misaligned load, rdata = 0.
- Undefined: port absent; misaligned accesses are force-aligned as described in Behaviour.

Test Plan:
- Reset: drive rstn = 0 mid-cycle after writing 0xDEADBEEF to addr 0x10 -> LW at 0x10 returns 0x00000000 immediately, without waiting for a clock edge.
- Word round-trip: SW 0x12345678 at 0x20 -> LW 0x20 = 0x12345678; LBU 0x20 = 0x78; LBU 0x23 = 0x12; LHU 0x22 = 0x1234.
- Sign extension: SB 0x80 at 0x31 over a zeroed word -> LB 0x31 = 0xFFFFFF80; LBU 0x31 = 0x00000080; LW 0x30 = 0x00008000.
- Partial store preserves neighbours: SW 0xAABBCCDD at 0x40, then SH 0x1122 at 0x42 -> LW 0x40 = 0x1122CCDD; LH 0x42 = 0x00001122.
- Read-before-write and aliasing: with we = 1 (SW 0x55 to 0x50), rdata in the same cycle shows the old value and the new one next cycle; LW at 0x50 + 4*DEPTH_WORDS returns the same data.
- Misaligned: SW 0xCAFEF00D at 0x61. Without the macro, the word at 0x60 = 0xCAFEF00D. With DATA_MEMORY_MISALIGN_TRAP_EN, misaligned = 1 and the word at 0x60 is unchanged.

Source files
------------

// File: rtl/data_memory.sv
// data_memory: byte-addressable 32-bit data memory for the mini RISC-V CPU.
// Serves RV32I loads/stores (LB, LH, LW, LBU, LHU, SB, SH, SW) selected by funct3.
// Loads are combinational and see the array as it was before this cycle's store;
// stores commit on the rising clock edge through per-byte enables.
// Optional build macro: DATA_MEMORY_MISALIGN_TRAP_EN
//   defined   -> adds 'misaligned' output; misaligned loads return 0, misaligned stores write nothing
//   undefined -> misaligned halfword/word accesses are forced to the aligned address
module data_memory #(
    parameter int DEPTH_WORDS = 64,
    parameter int AW          = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    input  logic          we,
    input  logic [2:0]    funct3,
    output logic [31:0]   rdata
`ifdef DATA_MEMORY_MISALIGN_TRAP_EN
    ,
    output logic          misaligned
`endif
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0]      mem [DEPTH_WORDS];
    logic [IDX_W-1:0] word_idx;
    logic [1:0]       off;
    logic             is_half;
    logic             is_word;
    logic [31:0]      rd_word;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [3:0]       byte_en;
    logic [31:0]      wr_data;

    assign word_idx = addr[IDX_W+1:2];
    assign is_half  = (funct3[1:0] == 2'b01);
    assign is_word  = (funct3 == 3'b010);

    // Address bits above the word index alias silently and are deliberately ignored.
    if (AW > IDX_W + 2) begin : g_alias
        logic unused_addr_hi;
        assign unused_addr_hi = ^addr[AW-1:IDX_W+2];
    end

`ifdef DATA_MEMORY_MISALIGN_TRAP_EN
    logic mis_access;

    // Flag halfword accesses on odd bytes and word accesses off a word boundary.
    always_comb begin
        mis_access = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
    end

    assign misaligned = mis_access;
`endif

    // Effective byte offset: low bits a wider access cannot use are dropped.
    always_comb begin
        off = addr[1:0];
        if (is_half) begin
            off[0] = 1'b0;
        end
        if (is_word) begin
            off = 2'b00;
        end
    end

    // Select the addressed byte and halfword out of the stored word.
    always_comb begin
        rd_word = mem[word_idx];
        rd_byte = rd_word[{off, 3'b000} +: 8];
        rd_half = off[1] ? rd_word[31:16] : rd_word[15:0];
    end

    // Format the load result with sign or zero extension.
    always_comb begin
        case (funct3)
            3'b000:  rdata = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  rdata = {24'h0, rd_byte};
            3'b001:  rdata = {{16{rd_half[15]}}, rd_half};
            3'b101:  rdata = {16'h0, rd_half};
            3'b010:  rdata = rd_word;
            default: rdata = 32'h0;
        endcase
`ifdef DATA_MEMORY_MISALIGN_TRAP_EN
        if (mis_access) begin
            rdata = 32'h0;
        end
`endif
        if (!rstn) begin
            rdata = 32'h0;
        end
    end

    // Build per-byte write enables and lane-replicated store data.
    always_comb begin
        byte_en = 4'b0000;
        wr_data = wdata;
        if (we) begin
            case (funct3)
                3'b000: begin
                    byte_en = 4'b0001 << off;
                    wr_data = {4{wdata[7:0]}};
                end
                3'b001: begin
                    byte_en = off[1] ? 4'b1100 : 4'b0011;
                    wr_data = {2{wdata[15:0]}};
                end
                3'b010: begin
                    byte_en = 4'b1111;
                    wr_data = wdata;
                end
                default: byte_en = 4'b0000;
            endcase
        end
`ifdef DATA_MEMORY_MISALIGN_TRAP_EN
        if (mis_access) begin
            byte_en = 4'b0000;
        end
`endif
    end

    // Array storage: async clear, byte-masked commit on the rising edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int w = 0; w < DEPTH_WORDS; w++) begin
                mem[w] <= 32'h0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed test-plan scenarios plus randomized traffic, all
// checked every cycle against a byte-array reference model of the memory.
module tb_data_memory;

    localparam int DEPTH     = 64;
    localparam int MEM_BYTES = 4 * DEPTH;

    logic        clk;
    logic        rstn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] rdata;
`ifdef DATA_MEMORY_MISALIGN_TRAP_EN
    logic        misaligned;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 0;

    logic [7:0] model_mem [MEM_BYTES];

    data_memory #(.DEPTH_WORDS(DEPTH), .AW(32)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .addr   (addr),
        .wdata  (wdata),
        .we     (we),
        .funct3 (funct3),
        .rdata  (rdata)
`ifdef DATA_MEMORY_MISALIGN_TRAP_EN
        ,
        .misaligned (misaligned)
`endif
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic int acc_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit model_mis(input logic [31:0] a, input logic [2:0] f3);
        int sz;
        sz = acc_size(f3);
        return (sz > 1) && ((a % sz) != 0);
    endfunction

    function automatic int model_base(input logic [31:0] a, input logic [2:0] f3);
        int unsigned b;
        int sz;
        sz = acc_size(f3);
        b  = a % MEM_BYTES;
        return int'(b - (b % sz));
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3);
        int sz;
        int base;
        logic [31:0] v;
        sz = acc_size(f3);
        if (rstn !== 1'b1 || sz == 0) return 32'h0;
`ifdef DATA_MEMORY_MISALIGN_TRAP_EN
        if (model_mis(a, f3)) return 32'h0;
`endif
        base = model_base(a, f3);
        v = 32'h0;
        for (int i = 0; i < sz; i++) v = v | (32'(model_mem[base + i]) << (8 * i));
        if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'h1 << (8 * sz)) - 32'h1);
        return v;
    endfunction

    function automatic void model_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
        int sz;
        int base;
        sz = (f3[2]) ? 0 : acc_size(f3);
        if (sz == 0) return;
`ifdef DATA_MEMORY_MISALIGN_TRAP_EN
        if (model_mis(a, f3)) return;
`endif
        base = model_base(a, f3);
        for (int i = 0; i < sz; i++) model_mem[base + i] = d[8*i +: 8];
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < MEM_BYTES; i++) model_mem[i] = 8'h0;
    endfunction

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: addr=%h funct3=%b got %h expected %h", name, addr, funct3, got, exp);
        end
    endfunction

    // Reference model commits stores on the same edge as the DUT.
    always @(posedge clk) begin
        if (rstn === 1'b1 && we === 1'b1) model_store(addr, funct3, wdata);
    end

    // Compare DUT outputs with the model away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            check("model_rdata", rdata, model_load(addr, funct3));
`ifdef DATA_MEMORY_MISALIGN_TRAP_EN
            check("model_misaligned", {31'h0, misaligned}, {31'h0, model_mis(addr, funct3)});
`endif
        end
    end

    task automatic op(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        we     = w;
        funct3 = f3;
        addr   = a;
        wdata  = d;
    endtask

    task automatic lit(input string name, input logic [31:0] exp);
        @(negedge clk);
        #1;
        check(name, rdata, exp);
    endtask

    initial begin
        rstn   = 1;
        we     = 0;
        funct3 = 3'b010;
        addr   = 0;
        wdata  = 0;
        model_clear();
        #2;
        rstn = 0;
        #20;
        rstn = 1;
        check_en = 1;

        // Async reset mid-cycle wipes a freshly stored word.
        op(1, 3'b010, 32'h10, 32'hDEADBEEF);
        op(0, 3'b010, 32'h10, 32'h0);
        #1;
        check("pre_reset_lw", rdata, 32'hDEADBEEF);
        rstn = 0;
        model_clear();
        #1;
        check("reset_async_lw", rdata, 32'h0);
        op(0, 3'b010, 32'h10, 32'h0);
        rstn = 1;
        lit("after_reset_lw", 32'h0);

        // Word round trip.
        op(1, 3'b010, 32'h20, 32'h12345678);
        op(0, 3'b010, 32'h20, 32'h0);  lit("lw_20", 32'h12345678);
        op(0, 3'b100, 32'h20, 32'h0);  lit("lbu_20", 32'h00000078);
        op(0, 3'b100, 32'h23, 32'h0);  lit("lbu_23", 32'h00000012);
        op(0, 3'b101, 32'h22, 32'h0);  lit("lhu_22", 32'h00001234);

        // Sign extension.
        op(1, 3'b000, 32'h31, 32'h00000080);
        op(0, 3'b000, 32'h31, 32'h0);  lit("lb_31", 32'hFFFFFF80);
        op(0, 3'b100, 32'h31, 32'h0);  lit("lbu_31", 32'h00000080);
        op(0, 3'b010, 32'h30, 32'h0);  lit("lw_30", 32'h00008000);

        // Back-to-back partial store merge.
        op(1, 3'b010, 32'h40, 32'hAABBCCDD);
        op(1, 3'b001, 32'h42, 32'h00001122);
        op(0, 3'b010, 32'h40, 32'h0);  lit("lw_40", 32'h1122CCDD);
        op(0, 3'b001, 32'h42, 32'h0);  lit("lh_42", 32'h00001122);

        // Read-before-write and aliasing.
        op(1, 3'b010, 32'h50, 32'h11111111);
        op(1, 3'b010, 32'h50, 32'h00000055); lit("rbw_old", 32'h11111111);
        op(0, 3'b010, 32'h50, 32'h0);  lit("rbw_new", 32'h00000055);
        op(0, 3'b010, 32'h50 + 4 * DEPTH, 32'h0); lit("alias_lw", 32'h00000055);

        // Misaligned word store.
        op(1, 3'b010, 32'h60, 32'h01020304);
        op(1, 3'b010, 32'h61, 32'hCAFEF00D);
`ifdef DATA_MEMORY_MISALIGN_TRAP_EN
        @(negedge clk); #1;
        check("mis_flag", {31'h0, misaligned}, 32'h1);
        op(0, 3'b010, 32'h60, 32'h0);  lit("mis_word_60", 32'h01020304);
`else
        op(0, 3'b010, 32'h60, 32'h0);  lit("mis_word_60", 32'hCAFEF00D);
`endif

        // Randomized traffic; address range kept small half the time to force reuse.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(1, 0) == 1) a = a & 32'h0000_01FF;
            op($urandom_range(1, 0) == 1, 3'($urandom_range(7, 0)), a, $urandom);
            if ($urandom_range(299, 0) == 0) begin
                #2;
                rstn = 0;
                model_clear();
                @(posedge clk); #1;
                rstn = 1;
            end
        end

        op(0, 3'b010, 32'h0, 32'h0);
        @(negedge clk); #1;
        check_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
